// File: rtl/debug_program_loader_pkg.sv
// Shared constants, state encoding and helpers for the debug program loader.
package debug_program_loader_pkg;

   // Instruction width; the byte packer is built for exactly four bytes.
   localparam int unsigned NbData    = 32;
   // Default instruction-memory address width.
   localparam int unsigned AddrWidth = 10;
   // Opcode field [31:26] of the last instruction in a program.
   localparam logic [5:0]  HaltOp    = 6'b111111;

   typedef enum logic [2:0] {
      StIdle,
      StRecv,
      StSetup,
      StWrite,
      StHold,
      StFinish,
      StDone,
      StError
   } state_e;

   // True when the word carries the halt opcode.
   function automatic logic is_halt(input logic [31:0] word, input logic [5:0] op);
      return word[31:26] == op;
   endfunction

endpackage

// File: rtl/debug_program_loader_byte_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words. The completed word and its
// valid flag are combinational so the caller can register them on the 4th byte.
module debug_program_loader_byte_word_packer (
   input  logic        clock,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   // Only the first three bytes need storage; the 4th is taken straight from i_byte.
   logic [23:0] shift_q, shift_d;
   logic [1:0]  count_q, count_d;

   // Next-state for the shift register and byte counter; clear beats a byte.
   always_comb begin
      shift_d = shift_q;
      count_d = count_q;
      if (i_clear) begin
         shift_d = '0;
         count_d = '0;
      end else if (i_valid) begin
         shift_d = {shift_q[15:0], i_byte};
         count_d = count_q + 2'd1;  // wraps to 0 after the 4th byte
      end
   end

   // Packer state registers.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         shift_q <= '0;
         count_q <= '0;
      end else begin
         shift_q <= shift_d;
         count_q <= count_d;
      end
   end

   // Word completes on the 4th accepted byte.
   always_comb begin
      o_word       = {shift_q, i_byte};
      o_word_valid = i_valid && !i_clear && (count_q == 2'd3);
   end

endmodule

// File: rtl/debug_program_loader.sv
// Debug-unit program loader: packs UART bytes into instructions, writes them
// into instruction memory one at a time, then releases the pipeline after the
// halt instruction has been written.
module debug_program_loader
   import debug_program_loader_pkg::*;
#(
   parameter int unsigned NB_DATA = NbData,
   parameter int unsigned NB_ADDR = AddrWidth,
   parameter logic [5:0]  HALT_OP = HaltOp
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic               o_debug_unit,
   output logic [NB_DATA-1:0] o_inst_load,
   output logic [NB_ADDR-1:0] o_addr_inst_load,
   output logic               o_en_write,
   output logic               o_enable_pipe,
   output logic               o_en_read,
   output logic               o_done,
   output logic               o_overrun,
   output logic               o_overflow
);

   localparam logic [NB_ADDR-1:0] AddrOne = {{(NB_ADDR-1){1'b0}}, 1'b1};

   state_e state_q, state_d;

   logic               debug_unit_q, debug_unit_d;
   logic [NB_DATA-1:0] inst_load_q, inst_load_d;
   logic [NB_ADDR-1:0] addr_q, addr_d;
   logic               en_write_q, en_write_d;
   logic               run_q, run_d;
   logic               overrun_q, overrun_d;
   logic               overflow_q, overflow_d;

   logic        pack_valid;
   logic [31:0] pack_word;
   logic        pack_word_valid;
   logic        word_is_halt;
   logic        addr_at_max;
   logic        late_byte;

   // Bytes are only accepted while receiving; a restart discards a partial word.
   assign pack_valid = i_rx_valid && (state_q == StRecv);

   debug_program_loader_byte_word_packer u_packer (
      .clock        (clock),
      .i_reset      (i_reset),
      .i_clear      (i_start),
      .i_valid      (pack_valid),
      .i_byte       (i_rx_data),
      .o_word       (pack_word),
      .o_word_valid (pack_word_valid)
   );

   assign word_is_halt = is_halt(inst_load_q, HALT_OP);
   assign addr_at_max  = &addr_q;
   // A byte arriving while a word is still being written out is lost.
   assign late_byte    = i_rx_valid &&
                         (state_q inside {StSetup, StWrite, StHold, StFinish});

   // FSM state register.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state; i_start restarts the load from any state.
   always_comb begin
      state_d = state_q;
      if (i_start) begin
         state_d = StRecv;
      end else begin
         unique case (state_q)
            StIdle:   state_d = StIdle;
            StRecv:   if (pack_word_valid) state_d = StSetup;
            StSetup:  state_d = StWrite;
            StWrite:  state_d = StHold;
            StHold: begin
               if (word_is_halt) begin
                  state_d = StFinish;
               end else if (addr_at_max) begin
                  state_d = StError;
               end else begin
                  state_d = StRecv;
               end
            end
            StFinish: state_d = StDone;
            StDone:   state_d = StDone;
            StError:  state_d = StError;
         endcase
      end
   end

   // Output/datapath next values; outputs follow the state being entered.
   always_comb begin
      debug_unit_d = state_d inside {StRecv, StSetup, StWrite, StHold};
      en_write_d   = (state_d == StWrite);
      run_d        = (state_d == StDone);

      inst_load_d = inst_load_q;
      if (i_start) begin
         inst_load_d = '0;
      end else if ((state_q == StRecv) && pack_word_valid) begin
         inst_load_d = pack_word;
      end else if (state_q == StHold) begin
         inst_load_d = '0;
      end

      // Address advances when leaving HOLD for the next word or for FINISH.
      addr_d = addr_q;
      if (i_start) begin
         addr_d = '0;
      end else if ((state_q == StHold) && (state_d inside {StRecv, StFinish})) begin
         addr_d = addr_q + AddrOne;
      end

      overrun_d = overrun_q;
      if (i_start) begin
         overrun_d = 1'b0;
      end else if (late_byte) begin
         overrun_d = 1'b1;
      end

      overflow_d = overflow_q;
      if (i_start) begin
         overflow_d = 1'b0;
      end else if ((state_q == StHold) && (state_d == StError)) begin
         overflow_d = 1'b1;
      end
   end

   // Output and datapath registers.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         debug_unit_q <= 1'b0;
         inst_load_q  <= '0;
         addr_q       <= '0;
         en_write_q   <= 1'b0;
         run_q        <= 1'b0;
         overrun_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         debug_unit_q <= debug_unit_d;
         inst_load_q  <= inst_load_d;
         addr_q       <= addr_d;
         en_write_q   <= en_write_d;
         run_q        <= run_d;
         overrun_q    <= overrun_d;
         overflow_q   <= overflow_d;
      end
   end

   assign o_debug_unit     = debug_unit_q;
   assign o_inst_load      = inst_load_q;
   assign o_addr_inst_load = addr_q;
   assign o_en_write       = en_write_q;
   assign o_enable_pipe    = run_q;
   assign o_en_read        = run_q;
   assign o_done           = run_q;
   assign o_overrun        = overrun_q;
   assign o_overflow       = overflow_q;

endmodule

// File: tb/tb_debug_program_loader.sv
// Bench for debug_program_loader with a 4-bit address space.
module tb_debug_program_loader;

   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          i_reset;
   logic          i_start;
   logic [7:0]    i_rx_data;
   logic          i_rx_valid;
   logic          o_debug_unit;
   logic [31:0]   o_inst_load;
   logic [AW-1:0] o_addr_inst_load;
   logic          o_en_write;
   logic          o_enable_pipe;
   logic          o_en_read;
   logic          o_done;
   logic          o_overrun;
   logic          o_overflow;

   int vectors     = 0;
   int miscompares = 0;

   // Observed write history, filled by the monitor.
   int          cyc         = 0;
   int          strobes     = 0;
   int          last_strobe = -100;
   logic [31:0] mem_dut [DEPTH];

   // Reference model state.
   int          exp_addr;
   logic [31:0] prog [DEPTH];
   bit          in_error;

   debug_program_loader #(.NB_ADDR(AW)) dut (
      .clock            (clk),
      .i_reset          (i_reset),
      .i_start          (i_start),
      .i_rx_data        (i_rx_data),
      .i_rx_valid       (i_rx_valid),
      .o_debug_unit     (o_debug_unit),
      .o_inst_load      (o_inst_load),
      .o_addr_inst_load (o_addr_inst_load),
      .o_en_write       (o_en_write),
      .o_enable_pipe    (o_enable_pipe),
      .o_en_read        (o_en_read),
      .o_done           (o_done),
      .o_overrun        (o_overrun),
      .o_overflow       (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge index, write strobes and the memory image as seen on the port.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (o_en_write === 1'b1) begin
         strobes                     <= strobes + 1;
         last_strobe                 <= cyc;
         mem_dut[o_addr_inst_load]   <= o_inst_load;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_debug"}, {31'd0, o_debug_unit}, 0);
      check({tag, "_inst"}, o_inst_load, 0);
      check({tag, "_addr"}, {28'd0, o_addr_inst_load}, 0);
      check({tag, "_wr"}, {31'd0, o_en_write}, 0);
      check({tag, "_pipe"}, {31'd0, o_enable_pipe}, 0);
      check({tag, "_rd"}, {31'd0, o_en_read}, 0);
      check({tag, "_done"}, {31'd0, o_done}, 0);
      check({tag, "_ovr"}, {31'd0, o_overrun}, 0);
      check({tag, "_ovf"}, {31'd0, o_overflow}, 0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
   endtask

   task automatic do_start(input string tag);
      i_start = 1'b1;
      tick();
      i_start  = 1'b0;
      exp_addr = 0;
      in_error = 1'b0;
      check({tag, "_debug"}, {31'd0, o_debug_unit}, 1);
      check({tag, "_addr"}, {28'd0, o_addr_inst_load}, 0);
      check({tag, "_pipe"}, {31'd0, o_enable_pipe}, 0);
      check({tag, "_done"}, {31'd0, o_done}, 0);
      check({tag, "_ovr"}, {31'd0, o_overrun}, 0);
      check({tag, "_ovf"}, {31'd0, o_overflow}, 0);
   endtask

   function automatic logic [31:0] rand_plain_word();
      logic [31:0] w;
      w = $urandom;
      if (w[31:26] == 6'h3f) w[31:26] = 6'h00;
      return w;
   endfunction

   // Sends one word and follows it through setup/write/hold against the model.
   task automatic send_word(input logic [31:0] w, input bit inject);
      int  e_byte;
      bit  halt;
      halt = ((w >> 26) == 32'h3f);
      for (int i = 0; i < 4; i++) begin
         send_byte(8'((w >> (24 - 8 * i)) & 32'hff));
         if (i < 3) repeat ($urandom_range(0, 2)) tick();
      end
      e_byte = cyc - 1;
      check("setup_inst", o_inst_load, w);
      check("setup_wr", {31'd0, o_en_write}, 0);
      tick();
      check("write_wr", {31'd0, o_en_write}, 1);
      check("write_addr", {28'd0, o_addr_inst_load}, 32'(exp_addr));
      check("write_inst", o_inst_load, w);
      check("write_debug", {31'd0, o_debug_unit}, 1);
      if (inject) begin
         i_rx_data  = 8'($urandom);
         i_rx_valid = 1'b1;
      end
      tick();
      i_rx_valid = 1'b0;
      check("hold_wr", {31'd0, o_en_write}, 0);
      check("strobe_latency", 32'(last_strobe), 32'(e_byte + 2));
      if (inject) check("overrun_set", {31'd0, o_overrun}, 1);
      tick();
      if (halt) begin
         exp_addr = (exp_addr + 1) % DEPTH;
         check("finish_debug", {31'd0, o_debug_unit}, 0);
         check("finish_addr", {28'd0, o_addr_inst_load}, 32'(exp_addr));
         check("finish_pipe", {31'd0, o_enable_pipe}, 0);
         tick();
         check("done_pipe", {31'd0, o_enable_pipe}, 1);
         check("done_rd", {31'd0, o_en_read}, 1);
         check("done_done", {31'd0, o_done}, 1);
      end else if (exp_addr == DEPTH - 1) begin
         in_error = 1'b1;
         check("err_ovf", {31'd0, o_overflow}, 1);
         check("err_debug", {31'd0, o_debug_unit}, 0);
         check("err_pipe", {31'd0, o_enable_pipe}, 0);
      end else begin
         exp_addr++;
         check("next_addr", {28'd0, o_addr_inst_load}, 32'(exp_addr));
         check("next_inst", o_inst_load, 0);
         check("next_debug", {31'd0, o_debug_unit}, 1);
      end
   endtask

   initial begin
      int n;
      int s0;
      i_reset    = 1'b1;
      i_start    = 1'b0;
      i_rx_data  = 8'h00;
      i_rx_valid = 1'b0;
      exp_addr   = 0;
      in_error   = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      i_reset = 1'b0;
      tick();
      check_all_zero("idle");

      // Reset in the middle of a word, then a fresh load.
      do_start("start1");
      send_byte(8'hAA);
      send_byte(8'hBB);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      check_all_zero("midreset");
      do_start("start2");
      send_word(32'h3C01000A, 1'b0);

      // Abort from RECV and load an 11-word program ending in halt.
      do_start("start3");
      n = 11;
      for (int i = 0; i < n - 1; i++) prog[i] = rand_plain_word();
      prog[n - 1] = 32'hFC000000;
      s0 = strobes;
      for (int i = 0; i < n; i++) send_word(prog[i], 1'b0);
      check("prog_strobes", 32'(strobes - s0), 32'(n));
      check("prog_final_addr", {28'd0, o_addr_inst_load}, 32'(n));
      for (int i = 0; i < n; i++) check("prog_mem", mem_dut[i], prog[i]);
      repeat (3) tick();
      check("done_held", {31'd0, o_enable_pipe}, 1);

      // Restart from DONE; the reload carries a byte injected during WRITE.
      do_start("restart_done");
      n = 3;
      prog[0] = rand_plain_word();
      prog[1] = rand_plain_word();
      prog[2] = {6'h3f, 26'($urandom)};
      s0 = strobes;
      send_word(prog[0], 1'b1);
      send_word(prog[1], 1'b0);
      send_word(prog[2], 1'b0);
      check("reload_strobes", 32'(strobes - s0), 32'(n));
      for (int i = 0; i < n; i++) check("reload_mem", mem_dut[i], prog[i]);
      check("overrun_sticky", {31'd0, o_overrun}, 1);

      // Exhaust the address space without a halt.
      do_start("start_ovf");
      s0 = strobes;
      for (int i = 0; i < DEPTH; i++) begin
         prog[i] = rand_plain_word();
         send_word(prog[i], 1'b0);
      end
      check("ovf_state", {31'd0, in_error}, 1);
      check("ovf_strobes", 32'(strobes - s0), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) check("ovf_mem", mem_dut[i], prog[i]);
      send_byte(8'h5A);
      repeat (4) tick();
      check("err_byte_no_ovr", {31'd0, o_overrun}, 0);
      check("err_no_strobe", 32'(strobes - s0), 32'(DEPTH));
      check("err_pipe_low", {31'd0, o_enable_pipe}, 0);
      check("err_ovf_held", {31'd0, o_overflow}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
